// File: rtl/vram_text_engine.sv
// Bulk text-plane sequencer on VRAM port A: clear, fill row, scroll up; CPU accesses always win the port.
// Optional feature macro VRAM_TEXT_SCROLL_DN_EN enables OP 11 = scroll down (otherwise OP 11 is illegal).
module vram_text_engine #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 50,
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 24
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [1:0]    CMD_OP,
  input  logic [5:0]    CMD_ROW,
  input  logic [DW-1:0] CMD_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  input  logic          CPU_WREN,
  input  logic          CPU_RDEN,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [2:0]    CPU_WEA,
  input  logic [DW-1:0] CPU_WRDATA,
  output logic [DW-1:0] CPU_RDDATA,
  output logic [AW-1:0] V_ADDR,
  output logic [2:0]    V_WEA,
  output logic [DW-1:0] V_DIN,
  input  logic [DW-1:0] V_DOUT
);

  localparam logic [AW-1:0] LAST_CELL     = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0] COLS_A        = AW'(COLS);
  localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [6:0]    ROWS_7        = 7'(ROWS);
  localparam logic [31:0]   COLS_V        = 32'(COLS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SRD,
    ST_SCAP,
    ST_SWR,
    ST_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   last_q, last_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   capt_q, capt_d;
  logic            err_q, err_d;
`ifdef VRAM_TEXT_SCROLL_DN_EN
  logic            dn_q, dn_d;
`endif

  logic            cpu_req;
  logic [AW-1:0]   eng_addr;
  logic [2:0]      eng_wea;
  logic [DW-1:0]   eng_din;
  logic [AW-1:0]   row_base_w;

  // row * COLS as a sum of shifted copies, one per set bit of COLS
  function automatic logic [AW-1:0] row_base(input logic [5:0] row);
    logic [AW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (COLS_V[i]) acc = acc + (AW'(row) << i);
    end
    return acc;
  endfunction

  assign row_base_w = row_base(CMD_ROW);
  assign cpu_req    = CPU_WREN | CPU_RDEN;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    src_d    = src_q;
    last_d   = last_q;
    data_d   = data_q;
    capt_d   = capt_q;
    err_d    = err_q;
`ifdef VRAM_TEXT_SCROLL_DN_EN
    dn_d     = dn_q;
`endif
    eng_addr = '0;
    eng_wea  = '0;
    eng_din  = '0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          data_d = CMD_DATA;
          err_d  = 1'b0;
          case (CMD_OP)
            2'b00: begin
              addr_d  = '0;
              last_d  = LAST_CELL;
              state_d = ST_FILL;
            end
            2'b01: begin
              addr_d  = '0;
              src_d   = COLS_A;
              last_d  = LAST_CELL - COLS_A;
`ifdef VRAM_TEXT_SCROLL_DN_EN
              dn_d    = 1'b0;
`endif
              state_d = ST_SRD;
            end
            2'b10: begin
              if ({1'b0, CMD_ROW} < ROWS_7) begin
                addr_d  = row_base_w;
                last_d  = row_base_w + COLS_A - AW'(1);
                state_d = ST_FILL;
              end else begin
                err_d   = 1'b1;
                state_d = ST_FIN;
              end
            end
            default: begin
`ifdef VRAM_TEXT_SCROLL_DN_EN
              addr_d  = LAST_CELL;
              src_d   = LAST_CELL - COLS_A;
              last_d  = COLS_A;
              dn_d    = 1'b1;
              state_d = ST_SRD;
`else
              err_d   = 1'b1;
              state_d = ST_FIN;
`endif
            end
          endcase
        end
      end
      ST_FILL: begin
        eng_addr = addr_q;
        eng_wea  = 3'b111;
        eng_din  = data_q;
        if (!cpu_req) begin
          if (addr_q == last_q) state_d = ST_FIN;
          else                  addr_d  = addr_q + AW'(1);
        end
      end
      ST_SRD: begin
        eng_addr = src_q;
        if (!cpu_req) state_d = ST_SCAP;
      end
      ST_SCAP: begin
        // read data is already on V_DOUT; capture regardless of who owns the port now
        eng_addr = src_q;
        capt_d   = V_DOUT;
        state_d  = ST_SWR;
      end
      ST_SWR: begin
        eng_addr = addr_q;
        eng_wea  = 3'b111;
        eng_din  = capt_q;
        if (!cpu_req) begin
          if (addr_q == last_q) begin
            addr_d  = LAST_ROW_BASE;
            last_d  = LAST_CELL;
`ifdef VRAM_TEXT_SCROLL_DN_EN
            if (dn_q) begin
              addr_d = '0;
              last_d = COLS_A - AW'(1);
            end
`endif
            state_d = ST_FILL;
          end else begin
            addr_d  = addr_q + AW'(1);
            src_d   = src_q + AW'(1);
`ifdef VRAM_TEXT_SCROLL_DN_EN
            if (dn_q) begin
              addr_d = addr_q - AW'(1);
              src_d  = src_q - AW'(1);
            end
`endif
            state_d = ST_SRD;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      src_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      capt_q  <= '0;
      err_q   <= 1'b0;
`ifdef VRAM_TEXT_SCROLL_DN_EN
      dn_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      last_q  <= last_d;
      data_q  <= data_d;
      capt_q  <= capt_d;
      err_q   <= err_d;
`ifdef VRAM_TEXT_SCROLL_DN_EN
      dn_q    <= dn_d;
`endif
    end
  end

  always_comb begin
    V_ADDR = '0;
    V_WEA  = '0;
    V_DIN  = '0;
    if (RST_N) begin
      if (cpu_req) begin
        V_ADDR = CPU_ADDR;
        V_WEA  = CPU_WEA;
        V_DIN  = CPU_WRDATA;
      end else begin
        V_ADDR = eng_addr;
        V_WEA  = eng_wea;
        V_DIN  = eng_din;
      end
    end
  end

  assign CMD_READY  = RST_N && (state_q == ST_IDLE);
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = (state_q == ST_FIN);
  assign ERR        = (state_q == ST_FIN) && err_q;
  assign CPU_RDDATA = V_DOUT;

endmodule
